vga_pixel_out: RTL and testbench

//  Display-side consumer of the upscaled pixel FIFO that the frame reader fills.

---
 rtl/vga_pixel_out_if.sv | 24 ++
 rtl/vga_pixel_out.sv | 171 +++++++++++++++++
 tb/tb_vga_pixel_out.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pixel_out_if.sv
// Pixel FIFO link between the upstream frame reader and the VGA output stage.
// The display side pops words and requests a flush after an underrun.
interface vga_pixel_out_if;
  localparam int unsigned PIX_W = 24;

  logic             fifo_empty;
  logic [PIX_W-1:0] fifo_data;
  logic             fifo_re;
  logic             flush;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_re,
    output flush
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_re,
    input  flush
  );
endinterface

// File: rtl/vga_pixel_out.sv
// 640x480@60 VGA timing generator that streams pixels out of a FWFT FIFO.
// Underrun blanks the rest of the frame and flushes upstream until the next blanking.
module vga_pixel_out (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pix_ce,
  input  logic                   clr_underflow,
  vga_pixel_out_if.master        fifo,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   blank,
  output logic [7:0]             red,
  output logic [7:0]             green,
  output logic [7:0]             blue,
  output logic                   frame_start,
  output logic                   underflow
);

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned CNT_W    = 10;
  localparam int unsigned PIX_W    = 24;

  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    RESYNC = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0]   v_cnt_q, v_cnt_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               blank_q, blank_d;
  logic [PIX_W-1:0]   rgb_q, rgb_d;
  logic               frame_start_q, frame_start_d;
  logic               underflow_q, underflow_d;
  logic               flush_q, flush_d;

  logic active_c;
  logic origin_c;
  logic h_last_c;
  logic v_last_c;
  logic hs_on_c;
  logic vs_on_c;
  logic resync_done_c;
  logic pop_c;
  logic underrun_c;

  // Position decode from the current counter values
  always_comb begin
    active_c      = (h_cnt_q < CNT_W'(H_ACTIVE)) && (v_cnt_q < CNT_W'(V_ACTIVE));
    origin_c      = (h_cnt_q == '0) && (v_cnt_q == '0);
    h_last_c      = (h_cnt_q == CNT_W'(H_TOTAL - 1));
    v_last_c      = (v_cnt_q == CNT_W'(V_TOTAL - 1));
    hs_on_c       = (h_cnt_q >= CNT_W'(HS_START)) && (h_cnt_q < CNT_W'(HS_END));
    vs_on_c       = (v_cnt_q >= CNT_W'(VS_START)) && (v_cnt_q < CNT_W'(VS_END));
    resync_done_c = (h_cnt_q == '0) && (v_cnt_q == CNT_W'(V_ACTIVE));
    pop_c         = pix_ce && active_c && (state_q == RUN) && !fifo.fifo_empty && !rst;
    underrun_c    = pix_ce && active_c && (state_q == RUN) && fifo.fifo_empty;
  end

  // Next-state and next-output logic; everything holds between pixel ticks
  always_comb begin
    state_d       = state_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    blank_d       = blank_q;
    rgb_d         = rgb_q;
    frame_start_d = 1'b0;
    underflow_d   = underflow_q;
    flush_d       = flush_q;

    // A fresh underrun beats a simultaneous clear
    if (underrun_c) begin
      underflow_d = 1'b1;
    end else if (clr_underflow) begin
      underflow_d = 1'b0;
    end

    if (pix_ce) begin
      if (h_last_c) begin
        h_cnt_d = '0;
        v_cnt_d = v_last_c ? '0 : v_cnt_q + CNT_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
      end

      hsync_d       = !hs_on_c;
      vsync_d       = !vs_on_c;
      blank_d       = !pop_c;
      rgb_d         = pop_c ? fifo.fifo_data : '0;
      frame_start_d = origin_c && !fifo.fifo_empty && (state_q != RESYNC);

      case (state_q)
        IDLE: begin
          if (origin_c && !fifo.fifo_empty) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (active_c && fifo.fifo_empty) begin
            state_d = RESYNC;
          end
        end
        RESYNC: begin
          if (resync_done_c) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      flush_d = (state_d == RESYNC);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_q       <= 1'b1;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
      flush_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
      flush_q       <= flush_d;
    end
  end

  assign fifo.fifo_re = pop_c;
  assign fifo.flush   = flush_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign blank        = blank_q;
  assign red          = rgb_q[23:16];
  assign green        = rgb_q[15:8];
  assign blue         = rgb_q[7:0];
  assign frame_start  = frame_start_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_vga_pixel_out.sv
// Bench for vga_pixel_out: a raster-position model predicts every pin each clock,
// and directed steps measure sync timing, pop counts, underrun and reset behaviour.
module tb_vga_pixel_out;

  localparam int H_TOTAL = 800;
  localparam int FRAME   = 420000;

  logic       clk = 1'b0;
  logic       rst;
  logic       pix_ce;
  logic       clr_underflow;
  logic       hsync, vsync, blank, frame_start, underflow;
  logic [7:0] red, green, blue;

  vga_pixel_out_if fif ();

  vga_pixel_out dut (
    .clk           (clk),
    .rst           (rst),
    .pix_ce        (pix_ce),
    .clr_underflow (clr_underflow),
    .fifo          (fif),
    .hsync         (hsync),
    .vsync         (vsync),
    .blank         (blank),
    .red           (red),
    .green         (green),
    .blue          (blue),
    .frame_start   (frame_start),
    .underflow     (underflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: pixel ticks since reset, plus whether a frame is streaming or recovering
  int          ticks;
  bit          streaming, recovering;
  bit          data_random;
  logic [23:0] head;
  logic        e_hs, e_vs, e_blank, e_fs, e_uf, e_flush;
  logic [23:0] e_rgb;

  int          cyc, pops, first_vis;
  logic [23:0] first_rgb;
  logic        last_hs;
  int          hs_fall[$];
  int          hs_rise[$];
  int          fs_cyc[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit in_blank();
    int pos;
    pos = ticks % FRAME;
    return !(((pos % H_TOTAL) < 640) && ((pos / H_TOTAL) < 480));
  endfunction

  function automatic int qget(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  task automatic begin_phase();
    cyc = 0;
    pops = 0;
    first_vis = -1;
    first_rgb = 24'hxxxxxx;
    hs_fall.delete();
    hs_rise.delete();
    fs_cyc.delete();
  endtask

  // One clock: drive inputs, check the pop strobe, clock, then check every output pin
  task automatic step(input bit i_rst, input bit i_ce, input bit i_empty, input bit i_clr);
    int pos, h, v;
    bit act, pop_e, und;
    rst             = i_rst;
    pix_ce          = i_ce;
    fif.fifo_empty  = i_empty;
    fif.fifo_data   = head;
    clr_underflow   = i_clr;
    pos   = ticks % FRAME;
    h     = pos % H_TOTAL;
    v     = pos / H_TOTAL;
    act   = (h < 640) && (v < 480);
    pop_e = !i_rst && i_ce && act && streaming && !i_empty;
    und   = !i_rst && i_ce && act && streaming && i_empty;
    #2;
    chk("fifo_re", 64'(fif.fifo_re), 64'(pop_e));
    if (fif.fifo_re === 1'b1) pops++;
    @(posedge clk);
    #1;
    cyc++;
    if (i_rst) begin
      ticks = 0; streaming = 0; recovering = 0;
      e_hs = 1; e_vs = 1; e_blank = 1; e_rgb = '0; e_fs = 0; e_uf = 0; e_flush = 0;
    end else begin
      e_fs = 0;
      if (und) e_uf = 1;
      else if (i_clr) e_uf = 0;
      if (i_ce) begin
        e_fs = (pos == 0) && !i_empty && !recovering;
        if (und) begin
          streaming = 0;
          recovering = 1;
        end else if (recovering && pos == 480 * H_TOTAL) begin
          recovering = 0;
        end else if (!streaming && !recovering && pos == 0 && !i_empty) begin
          streaming = 1;
        end
        e_hs    = !(h >= 656 && h < 752);
        e_vs    = !(v >= 490 && v < 492);
        e_blank = !pop_e;
        e_rgb   = pop_e ? head : 24'h0;
        e_flush = recovering;
        ticks++;
        if (pop_e) head = data_random ? 24'($urandom) : head + 24'd1;
      end
    end
    chk("pins{hs,vs,blank,fs,uf,flush,rgb}",
        64'({hsync, vsync, blank, frame_start, underflow, fif.flush, red, green, blue}),
        64'({e_hs, e_vs, e_blank, e_fs, e_uf, e_flush, e_rgb}));
    if (last_hs === 1'b1 && hsync === 1'b0) hs_fall.push_back(cyc);
    if (last_hs === 1'b0 && hsync === 1'b1) hs_rise.push_back(cyc);
    last_hs = hsync;
    if (frame_start === 1'b1) fs_cyc.push_back(cyc);
    if (first_vis < 0 && blank === 1'b0) begin
      first_vis = cyc;
      first_rgb = {red, green, blue};
    end
  endtask

  initial begin
    int w0;
    ticks = 0; streaming = 0; recovering = 0; data_random = 0; head = '0;
    last_hs = 1'b1;
    begin_phase();

    // Reset values
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("reset_hsync", 64'(hsync), 64'(1));
    chk("reset_blank", 64'(blank), 64'(1));
    chk("reset_rgb", 64'({red, green, blue}), 64'(0));

    // Incrementing pattern, pix_ce every clock, random FIFO gaps only in blanking
    head = 24'h0;
    data_random = 0;
    begin_phase();
    for (int i = 0; i < 1700; i++) step(0, 1, in_blank() ? 1'($urandom_range(0, 1)) : 1'b0, 0);
    chk("frame_start_cyc", 64'(qget(fs_cyc, 0)), 64'(1));
    chk("first_visible_cyc", 64'(first_vis), 64'(2));
    chk("first_visible_rgb", 64'(first_rgb), 64'(0));
    chk("hsync_fall", 64'(qget(hs_fall, 0)), 64'(657));
    chk("hsync_rise", 64'(qget(hs_rise, 0)), 64'(753));
    chk("line_period", 64'(qget(hs_fall, 1) - qget(hs_fall, 0)), 64'(800));
    chk("pops_two_lines", 64'(pops), 64'(639 + 640 + 100));

    // Reset while streaming an active pixel: no pop on the reset edge
    step(1, 1, 0, 0);
    chk("rst_mid_hsync", 64'({hsync, vsync, blank}), 64'(3'b111));
    chk("rst_mid_rgb", 64'({red, green, blue}), 64'(0));

    // pix_ce every 4th clock with random pixel data
    data_random = 1;
    head = 24'($urandom);
    begin_phase();
    for (int i = 0; i < 6000; i++) step(0, (i % 4) == 3, in_blank() ? 1'($urandom_range(0, 1)) : 1'b0, 0);
    chk("ce4_frame_start_cyc", 64'(qget(fs_cyc, 0)), 64'(4));
    chk("ce4_frame_start_len", 64'(fs_cyc.size()), 64'(1));
    chk("ce4_hsync_fall", 64'(qget(hs_fall, 0)), 64'(2628));
    chk("ce4_hsync_width", 64'(qget(hs_rise, 0) - qget(hs_fall, 0)), 64'(384));
    chk("ce4_line_period", 64'(qget(hs_fall, 1) - qget(hs_fall, 0)), 64'(3200));

    // Underrun at pixel (100,10)
    step(1, 1, 0, 0);
    data_random = 0;
    head = 24'h100000;
    begin_phase();
    while (ticks < 10 * H_TOTAL + 100) step(0, 1, in_blank() ? 1'($urandom_range(0, 1)) : 1'b0, 0);
    step(0, 1, 1, 0);
    chk("underrun_flag", 64'(underflow), 64'(1));
    chk("underrun_blank", 64'({blank, red, green, blue}), 64'({1'b1, 24'h0}));
    chk("underrun_flush", 64'(fif.flush), 64'(1));
    w0 = pops;
    while (ticks < 12 * H_TOTAL + 319) step(0, 1, 1'($urandom_range(0, 1)), 0);
    chk("resync_no_pops", 64'(pops - w0), 64'(0));
    chk("resync_flush_held", 64'(fif.flush), 64'(1));
    step(0, 1, 0, 1);
    chk("clr_underflow", 64'(underflow), 64'(0));

    // FIFO empty at (0,0): stay idle for the frame
    step(1, 1, 0, 0);
    begin_phase();
    step(0, 1, 1, 0);
    for (int i = 0; i < 900; i++) step(0, 1, 0, 0);
    chk("idle_no_pops", 64'(pops), 64'(0));
    chk("idle_no_frame_start", 64'(fs_cyc.size()), 64'(0));

    // Clear and new underrun on the same edge: set wins
    step(1, 1, 0, 0);
    begin_phase();
    while (ticks < 5) step(0, 1, 0, 0);
    step(0, 1, 1, 1);
    chk("set_beats_clear", 64'(underflow), 64'(1));
    step(0, 1, 0, 1);
    chk("clear_after_set", 64'(underflow), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
